// File: rtl/led_pkg.sv
// Shared definitions for the LED blink-rate path: divider width, FSM state
// encodings and the default divider loaded at reset.
package led_pkg;

  localparam int DIV_W            = 5;
  localparam int DIV_INIT_DEFAULT = 20;

  localparam logic [1:0] ST_INIT_ENC = 2'd0;
  localparam logic [1:0] ST_IDLE_ENC = 2'd1;
  localparam logic [1:0] ST_HOLD_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_INIT = ST_INIT_ENC,
    ST_IDLE = ST_IDLE_ENC,
    ST_HOLD = ST_HOLD_ENC
  } state_e;

  // Truncate an integer parameter to the divider width.
  function automatic logic [DIV_W-1:0] to_div(input int value);
    return value[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/led_div_ctrl_btn_debounce.sv
// Conditions one raw push-button: two-flop synchroniser, stable-level
// debounce counter, and a one-cycle press pulse on each debounced 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk100,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Count consecutive cycles the synchronised input disagrees with the
  // debounced level; accept the new level once the count runs out.
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Register synchroniser, counter, level and press pulse.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/led_div_ctrl.sv
// Turns debounced up/down button presses into saturating divider writes
// for the LED counter, with one write strobe per accepted change.
module led_div_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DIV_INIT        = DIV_INIT_DEFAULT,
  parameter int DIV_MIN         = 0,
  parameter int DIV_MAX         = 31
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             btn_up_i,
  input  logic             btn_dn_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] DIV_INIT_V = to_div(DIV_INIT);
  localparam logic [DIV_W-1:0] DIV_MIN_V  = to_div(DIV_MIN);
  localparam logic [DIV_W-1:0] DIV_MAX_V  = to_div(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_ONE    = to_div(1);

  logic up_level, up_press;
  logic dn_level, dn_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .clk100  (clk100),
    .rst     (rst),
    .btn_i   (btn_up_i),
    .level_o (up_level),
    .press_o (up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dn (
    .clk100  (clk100),
    .rst     (rst),
    .btn_i   (btn_dn_i),
    .level_o (dn_level),
    .press_o (dn_press)
  );

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic             wren_q,  wren_d;
  logic             busy_q,  busy_d;

  // Next-state logic: announce the reset value once, then step the divider
  // on single presses and park in HOLD until both buttons are let go.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    wren_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
        div_d   = DIV_INIT_V;
        wren_d  = 1'b1;
      end
      ST_IDLE: begin
        if (up_press && dn_press) begin
          state_d = ST_HOLD;
        end else if (up_press) begin
          state_d = ST_HOLD;
          if (div_q < DIV_MAX_V) begin
            div_d  = div_q + DIV_ONE;
            wren_d = 1'b1;
          end
        end else if (dn_press) begin
          state_d = ST_HOLD;
          if (div_q > DIV_MIN_V) begin
            div_d  = div_q - DIV_ONE;
            wren_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!up_level && !dn_level) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Register FSM state and all outputs.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      div_q   <= DIV_INIT_V;
      wren_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
    end
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_led_div_ctrl.sv
// Scoreboard bench for led_div_ctrl with a short debounce window: stimulus
// queues the expected writes, a monitor checks every wren_o pulse.
module tb_led_div_ctrl;

  logic       clk100 = 1'b0;
  logic       rst    = 1'b1;
  logic       btn_up_i = 1'b0;
  logic       btn_dn_i = 1'b0;
  logic [4:0] div_o;
  logic       wren_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [4:0] div;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  led_div_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk100   (clk100),
    .rst      (rst),
    .btn_up_i (btn_up_i),
    .btn_dn_i (btn_dn_i),
    .div_o    (div_o),
    .wren_o   (wren_o),
    .busy_o   (busy_o)
  );

  // 100 MHz clock and a free-running cycle counter.
  always #5 clk100 = ~clk100;

  always @(posedge clk100) cyc <= cyc + 1;

  // Monitor: pop an expectation for every write strobe and check the
  // strobe and divider invariants outside reset.
  initial begin
    logic       prev_wren = 1'b0;
    logic [4:0] prev_div  = 5'd0;
    logic       prev_rst  = 1'b1;
    exp_t       e;
    forever begin
      @(negedge clk100);
      #1;
      if (!rst && !prev_rst) begin
        checks++;
        if (prev_wren && wren_o) begin
          errors++;
          $display("[TB] FAIL wren_back_to_back at cycle %0d: wren_o high two cycles running", cyc);
        end
        checks++;
        if (div_o != prev_div && !wren_o) begin
          errors++;
          $display("[TB] FAIL div_change_without_wren at cycle %0d: div_o %0d (was %0d)", cyc, div_o, prev_div);
        end
      end
      if (wren_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write at cycle %0d: div_o %0d, no write expected", cyc, div_o);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (div_o != e.div) begin
            errors++;
            $display("[TB] FAIL write_div at cycle %0d: got %0d, expected %0d", cyc, div_o, e.div);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("[TB] FAIL write_cycle: got cycle %0d, expected cycle %0d", cyc, e.cyc);
          end
        end
      end
      prev_wren = wren_o;
      prev_div  = div_o;
      prev_rst  = rst;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Every queued write must have been seen by now.
  task automatic check_drained(input string name);
    check_output(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Press the given buttons for hold cycles, release, and wait until the
  // release has been debounced and the FSM is back in IDLE.
  task automatic apply_stimulus(input bit up, input bit dn, input int hold,
                                input bit expect_write, input logic [4:0] exp_div);
    if (expect_write) exp_q.push_back('{div: exp_div, cyc: cyc + 7});
    btn_up_i = up;
    btn_dn_i = dn;
    tick(hold);
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    tick(12);
    check_output("busy_after_release", busy_o, 0);
    check_drained("press_write_seen");
  endtask

  initial begin
    int c;
    int model;

    // Reset values and the INIT write.
    tick(3);
    check_output("reset_div", div_o, 20);
    check_output("reset_wren", wren_o, 0);
    check_output("reset_busy", busy_o, 1);
    exp_q.push_back('{div: 5'd20, cyc: cyc + 1});
    rst = 1'b0;
    tick(2);
    check_output("busy_after_init", busy_o, 0);
    tick(5);
    check_drained("init_write_seen");

    // Clean up press held 20 cycles.
    c = cyc;
    exp_q.push_back('{div: 5'd21, cyc: c + 7});
    btn_up_i = 1'b1;
    tick(7);
    check_output("busy_on_write", busy_o, 1);
    tick(13);
    btn_up_i = 1'b0;
    tick(6);
    check_output("busy_before_release_done", busy_o, 1);
    tick(1);
    check_output("busy_after_release_done", busy_o, 0);
    tick(5);
    check_drained("clean_press_write_seen");
    check_output("clean_press_div", div_o, 21);

    // Bounce then stable high: one write only.
    for (int i = 0; i < 3; i++) begin
      btn_up_i = 1'b1;
      tick(2);
      btn_up_i = 1'b0;
      tick(2);
    end
    check_output("bounce_no_change", div_o, 21);
    apply_stimulus(1'b1, 1'b0, 10, 1'b1, 5'd22);
    check_output("bounce_div", div_o, 22);

    // Reset while in HOLD at 25.
    apply_stimulus(1'b1, 1'b0, 8, 1'b1, 5'd23);
    apply_stimulus(1'b1, 1'b0, 8, 1'b1, 5'd24);
    exp_q.push_back('{div: 5'd25, cyc: cyc + 7});
    btn_up_i = 1'b1;
    tick(9);
    check_output("hold_div_25", div_o, 25);
    check_output("hold_busy", busy_o, 1);
    check_drained("write_25_seen");
    rst = 1'b1;
    btn_up_i = 1'b0;
    #1;
    check_output("async_reset_div", div_o, 20);
    check_output("async_reset_wren", wren_o, 0);
    check_output("async_reset_busy", busy_o, 1);
    tick(3);
    exp_q.push_back('{div: 5'd20, cyc: cyc + 1});
    rst = 1'b0;
    tick(8);
    check_drained("reinit_write_seen");
    check_output("reinit_div", div_o, 20);

    // Saturate at the top, then at the bottom.
    model = 20;
    while (model < 31) begin
      model++;
      apply_stimulus(1'b1, 1'b0, 8, 1'b1, 5'(model));
    end
    check_output("top_reached", div_o, 31);
    apply_stimulus(1'b1, 1'b0, 8, 1'b0, 5'd0);
    check_output("top_saturated", div_o, 31);
    while (model > 0) begin
      model--;
      apply_stimulus(1'b0, 1'b1, 8, 1'b1, 5'(model));
    end
    check_output("bottom_reached", div_o, 0);
    apply_stimulus(1'b0, 1'b1, 8, 1'b0, 5'd0);
    check_output("bottom_saturated", div_o, 0);

    // Both buttons together, then an up press while still in HOLD.
    btn_up_i = 1'b1;
    btn_dn_i = 1'b1;
    tick(10);
    check_output("both_busy", busy_o, 1);
    btn_up_i = 1'b0;
    tick(10);
    btn_up_i = 1'b1;
    tick(10);
    check_output("hold_press_busy", busy_o, 1);
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    tick(12);
    check_output("both_div_unchanged", div_o, 0);
    check_drained("both_no_write");
    apply_stimulus(1'b1, 1'b0, 8, 1'b1, 5'd1);
    check_output("after_hold_div", div_o, 1);

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
